// File: rtl/rr_requester_bank.sv
// rr_requester_bank
//   Requester side of a 4-way round-robin arbiter. Each channel keeps a count
//   of pending jobs. It requests the arbiter while jobs are waiting. On every
//   accepted one-hot grant it runs a fixed BURST_LEN-beat transfer. The block
//   also checks that grants are legal and keeps sticky error flags.
//
// Optional feature (macro RR_REQ_STARVE_MON_EN):
//   Adds parameter STARVE_LIM and output o_starve. Each channel counts its
//   cycles in WAIT. o_starve[ch] is set, and stays set, once the count reaches
//   STARVE_LIM.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous reset, active low
//   i_push       per-channel job enqueue strobe
//   i_gnt        grant from arbiter (one-hot or zero expected)
//   o_req        registered request to arbiter
//   o_beat       transfer beat strobe, high every cycle of a burst
//   o_done       pulse on the last beat of a burst
//   o_full       pending count == MAX_PEND
//   o_ovf        sticky: push dropped while full
//   o_err_multi  sticky: more than one grant bit set
//   o_err_spur   sticky: grant to a channel in IDLE
//   o_starve     sticky starvation flag (RR_REQ_STARVE_MON_EN only)
//
// Channel FSM:
//   state   | meaning
//   ST_IDLE | no pending job, not requesting
//   ST_WAIT | jobs pending, requesting until a grant is accepted
//   ST_XFER | running a BURST_LEN-beat transfer, grant ignored
module rr_requester_bank #(
    parameter int NUM_CH     = 4,
    parameter int MAX_PEND   = 7,
    parameter int BURST_LEN  = 4
`ifdef RR_REQ_STARVE_MON_EN
    ,
    parameter int STARVE_LIM = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_push,
    input  logic [NUM_CH-1:0] i_gnt,
`ifdef RR_REQ_STARVE_MON_EN
    output logic [NUM_CH-1:0] o_starve,
`endif
    output logic [NUM_CH-1:0] o_req,
    output logic [NUM_CH-1:0] o_beat,
    output logic [NUM_CH-1:0] o_done,
    output logic [NUM_CH-1:0] o_full,
    output logic [NUM_CH-1:0] o_ovf,
    output logic              o_err_multi,
    output logic              o_err_spur
);

    localparam int CNT_W  = $clog2(MAX_PEND + 1);
    localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
`ifdef RR_REQ_STARVE_MON_EN
    localparam int SCNT_W = $clog2(STARVE_LIM + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    logic [NUM_CH-1:0] w_spur;
    logic              r_err_multi;
    logic              r_err_spur;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t             r_state;
        state_t             w_state_nxt;
        logic [CNT_W-1:0]   r_cnt;
        logic [CNT_W-1:0]   w_cnt_nxt;
        logic [BCNT_W-1:0]  r_bcnt;
        logic [BCNT_W-1:0]  w_bcnt_nxt;
        logic               r_ovf;
        logic               w_ovf_nxt;
        logic               r_req;
        logic               w_acc;
        logic               w_last;

        always_comb begin
            w_acc       = (r_state == ST_WAIT) && i_gnt[g];
            w_last      = (r_state == ST_XFER) && (r_bcnt == BCNT_W'(BURST_LEN - 1));
            w_cnt_nxt   = r_cnt;
            w_ovf_nxt   = r_ovf;
            w_state_nxt = r_state;
            w_bcnt_nxt  = r_bcnt;

            // A push and an accepted grant in the same cycle cancel out. The
            // push is not dropped even when the count is at MAX_PEND.
            if (w_acc) begin
                if (!i_push[g]) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end else if (i_push[g]) begin
                if (r_cnt == CNT_W'(MAX_PEND)) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_push[g]) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_acc) begin
                        w_state_nxt = ST_XFER;
                        w_bcnt_nxt  = '0;
                    end
                end
                ST_XFER: begin
                    // The decision uses the post-update count, so a push that
                    // arrives on the last beat still brings the channel back
                    // to WAIT.
                    if (w_last) begin
                        w_state_nxt = (w_cnt_nxt != '0) ? ST_WAIT : ST_IDLE;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_bcnt  <= '0;
                r_ovf   <= 1'b0;
                r_req   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_bcnt  <= w_bcnt_nxt;
                r_ovf   <= w_ovf_nxt;
                r_req   <= (w_state_nxt == ST_WAIT);
            end
        end

`ifdef RR_REQ_STARVE_MON_EN
        logic [SCNT_W-1:0] r_scnt;
        logic              r_starve;

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                r_scnt   <= '0;
                r_starve <= 1'b0;
            end else begin
                if (w_acc) begin
                    r_scnt <= '0;
                end else if ((r_state == ST_WAIT) && (r_scnt != SCNT_W'(STARVE_LIM))) begin
                    r_scnt <= r_scnt + 1'b1;
                end
                // Set on the same edge where the counter reaches the limit.
                if ((r_state == ST_WAIT) && !w_acc && (r_scnt == SCNT_W'(STARVE_LIM - 1))) begin
                    r_starve <= 1'b1;
                end
            end
        end

        assign o_starve[g] = r_starve;
`endif

        assign o_req[g]  = r_req;
        assign o_beat[g] = (r_state == ST_XFER);
        assign o_done[g] = w_last;
        assign o_full[g] = (r_cnt == CNT_W'(MAX_PEND));
        assign o_ovf[g]  = r_ovf;
        assign w_spur[g] = (r_state == ST_IDLE) && i_gnt[g];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err_multi <= 1'b0;
            r_err_spur  <= 1'b0;
        end else begin
            if ($countones(i_gnt) > 1) begin
                r_err_multi <= 1'b1;
            end
            if (|w_spur) begin
                r_err_spur <= 1'b1;
            end
        end
    end

    assign o_err_multi = r_err_multi;
    assign o_err_spur  = r_err_spur;

endmodule
